lut_config_loader: RTL and testbench



---
 rtl/lut_cfg_pkg.sv | 35 +++
 rtl/lut_config_loader_shifter.sv | 45 ++++
 rtl/lut_config_loader.sv | 149 ++++++++++++++
 tb/tb_lut_config_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the LUT configuration loader.
// Contents:
//   state_e         - loader FSM states
//   cfg_width       - frame width for a (split) LUT with a given input count
//   words_per_frame - bitstream words needed to fill one frame
//   cnt_width       - counter width for a modulus, never below 1 bit
package lut_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCommit,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned DefInputs = 4;

    // A split LUT carries two half-LUT memories in one frame.
    function automatic int unsigned cfg_width(input int unsigned inputs, input bit split);
        int unsigned mem_size;
        mem_size = 32'd1 << inputs;
        return split ? 2 * mem_size : mem_size;
    endfunction

    function automatic int unsigned words_per_frame(input int unsigned cfg_w,
                                                    input int unsigned word_w);
        return cfg_w / word_w;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_config_loader_shifter.sv
// cfg_frame_shifter: MSB-first frame assembly register.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   clear      in   restart word counting (start of a sequence)
//   load       in   shift din in this cycle
//   din        in   WORD_W bitstream word
//   frame_next out  frame including din; the complete frame when last is high
//   last       out  din is the final word of the current frame
module cfg_frame_shifter
    import lut_cfg_pkg::*;
#(
    parameter int unsigned CFG_W  = 32,
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] din,
    output logic [CFG_W-1:0]  frame_next,
    output logic              last
);

    localparam int unsigned WPF = words_per_frame(CFG_W, WORD_W);
    localparam int unsigned CW  = cnt_width(WPF);

    logic [CFG_W-1:0] frame_q;
    logic [CW-1:0]    word_cnt;

    // Older words move toward the MSB; with CFG_W == WORD_W the shift empties frame_q.
    assign frame_next = (frame_q << WORD_W) | CFG_W'(din);
    assign last       = load && (word_cnt == CW'(WPF - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            frame_q  <= '0;
            word_cnt <= '0;
        end else if (load) begin
            frame_q  <= frame_next;
            word_cnt <= last ? '0 : word_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lut_config_loader.sv
// lut_config_loader: assembles word-serial bitstream frames and writes one frame per target
// LUT by pulsing its cen while the frame sits on the shared config bus.
// Optional feature: define LUT_CONFIG_LOADER_CHECKSUM_EN to add a trailing XOR checksum word
// after the last frame; otherwise err is tied low.
// Ports:
//   cclk       in   configuration clock
//   rst        in   synchronous active-high reset (aborts a sequence in flight)
//   start      in   begin a load sequence (honoured in idle/done only)
//   in_data    in   bitstream word
//   in_valid   in   in_data valid
//   in_ready   out  word accepted this cycle when in_valid is high
//   config_out out  shared config bus, updated only on commit
//   cen_out    out  one-hot, one-cycle write strobe per target
//   busy       out  sequence in progress
//   done       out  sequence completed, held until next start
//   err        out  checksum mismatch, held until next start
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int unsigned INPUTS      = DefInputs,
    parameter int unsigned CFG_W       = cfg_width(INPUTS, 1'b1),
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned NUM_TARGETS = 4
) (
    input  logic                   cclk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WORD_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [CFG_W-1:0]       config_out,
    output logic [NUM_TARGETS-1:0] cen_out,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned TW = cnt_width(NUM_TARGETS);

    state_e           state;
    logic [TW-1:0]    tgt_idx;
    logic             load;
    logic             start_ok;
    logic             frame_last;
    logic [CFG_W-1:0] frame_next;

    assign load     = (state == StLoad) && in_valid && in_ready;
    assign start_ok = start && ((state == StIdle) || (state == StDone));

    cfg_frame_shifter #(
        .CFG_W (CFG_W),
        .WORD_W(WORD_W)
    ) u_shifter (
        .clk       (cclk),
        .rst       (rst),
        .clear     (start_ok),
        .load      (load),
        .din       (in_data),
        .frame_next(frame_next),
        .last      (frame_last)
    );

`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] acc;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge cclk) begin
        if (rst) begin
            state      <= StIdle;
            in_ready   <= 1'b0;
            cen_out    <= '0;
            config_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tgt_idx    <= '0;
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
            acc        <= '0;
            err        <= 1'b0;
`endif
        end else begin
            // Strobe is a single-cycle pulse unless commit re-asserts it.
            cen_out <= '0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state    <= StLoad;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        tgt_idx  <= '0;
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
                        acc      <= '0;
                        err      <= 1'b0;
`endif
                    end
                end
                StLoad: begin
                    if (load) begin
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
                        acc <= acc ^ in_data;
`endif
                        if (frame_last) begin
                            state      <= StCommit;
                            in_ready   <= 1'b0;
                            cen_out    <= NUM_TARGETS'(1) << tgt_idx;
                            config_out <= frame_next;
                        end
                    end
                end
                StCommit: begin
                    if (tgt_idx == TW'(NUM_TARGETS - 1)) begin
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
                        state    <= StCheck;
                        in_ready <= 1'b1;
`else
                        state    <= StDone;
                        busy     <= 1'b0;
                        done     <= 1'b1;
`endif
                    end else begin
                        state    <= StLoad;
                        in_ready <= 1'b1;
                        tgt_idx  <= tgt_idx + TW'(1);
                    end
                end
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
                StCheck: begin
                    // Trailer word is compared only, never written to a target.
                    if (in_valid) begin
                        err      <= (in_data != acc);
                        state    <= StDone;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
`endif
                default: begin
                    state    <= StIdle;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_config_loader.sv
`timescale 1ns/1ps
module tb_lut_config_loader;

    localparam int unsigned CFG_W  = 32;
    localparam int unsigned WORD_W = 8;
    localparam int unsigned NT     = 2;
    localparam int unsigned SW     = 16;

    logic              cclk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic [CFG_W-1:0]  config_out;
    logic [NT-1:0]     cen_out;
    logic              busy;
    logic              done;
    logic              err;

    logic              start2;
    logic              in_valid2;
    logic [SW-1:0]     in_data2;
    logic              in_ready2;
    logic [SW-1:0]     config_out2;
    logic [0:0]        cen_out2;
    logic              busy2;
    logic              done2;
    logic              err2;

    lut_config_loader #(
        .INPUTS     (4),
        .CFG_W      (CFG_W),
        .WORD_W     (WORD_W),
        .NUM_TARGETS(NT)
    ) dut (
        .cclk      (cclk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .config_out(config_out),
        .cen_out   (cen_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    lut_config_loader #(
        .INPUTS     (4),
        .CFG_W      (SW),
        .WORD_W     (SW),
        .NUM_TARGETS(1)
    ) dut_small (
        .cclk      (cclk),
        .rst       (rst),
        .start     (start2),
        .in_data   (in_data2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .config_out(config_out2),
        .cen_out   (cen_out2),
        .busy      (busy2),
        .done      (done2),
        .err       (err2)
    );

    always #5 cclk = ~cclk;

    // Counts strobes per target as seen on the rising edge.
    int pulses [NT];
    initial for (int i = 0; i < NT; i++) pulses[i] = 0;
    always @(posedge cclk) begin
        for (int i = 0; i < NT; i++) if (cen_out[i]) pulses[i] <= pulses[i] + 1;
    end

    typedef struct {
        logic [7:0]       w0, w1, w2, w3;
        logic [CFG_W-1:0] exp_cfg;
        logic [NT-1:0]    exp_cen;
    } vec_t;

    vec_t vecs [4];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   snap [NT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    function automatic logic [7:0] word_of(input vec_t v, input int k);
        case (k)
            0:       return v.w0;
            1:       return v.w1;
            2:       return v.w2;
            default: return v.w3;
        endcase
    endfunction

    function automatic logic [7:0] xor_model(input int base);
        logic [7:0] x = 8'h00;
        for (int t = 0; t < 2; t++)
            for (int k = 0; k < 4; k++) x = x ^ word_of(vecs[base + t], k);
        return x;
    endfunction

    // Offers one word, optionally after a one-cycle valid gap; bounded wait on in_ready.
    task automatic send_word(input logic [7:0] d, input bit gap);
        bit sent = 1'b0;
        if (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 20 && !sent; c++) begin
            if (in_ready) sent = 1'b1;
            tick();
        end
        if (!sent) check("handshake_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        snap  = pulses;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_ready", in_ready, 1);
        check("start_done_clr", done, 0);
        check("start_err_clr", err, 0);
    endtask

    task automatic run_frames(input int base, input bit gap, input bit start_mid);
        for (int t = 0; t < NT; t++) begin
            for (int k = 0; k < 4; k++) begin
                if (start_mid && t == 0 && k == 1) start = 1'b1;
                send_word(word_of(vecs[base + t], k), gap);
                start = 1'b0;
                if (k < 3) check("no_early_cen", cen_out, 0);
            end
            check("cen_commit", cen_out, vecs[base + t].exp_cen);
            check("cfg_commit", config_out, vecs[base + t].exp_cfg);
            check("ready_commit", in_ready, 0);
            tick();
            check("cen_fall", cen_out, 0);
            check("cfg_hold", config_out, vecs[base + t].exp_cfg);
        end
    endtask

    task automatic finish_seq(input logic [7:0] trailer, input bit exp_err);
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
        check("check_ready", in_ready, 1);
        check("check_done_low", done, 0);
        send_word(trailer, 1'b0);
`else
        // Words offered after completion must be ignored.
        in_valid = 1'b1;
        in_data  = trailer;
        tick();
        in_valid = 1'b0;
`endif
        check("seq_done", done, 1);
        check("seq_busy", busy, 0);
        check("seq_ready", in_ready, 0);
        check("seq_err", err, exp_err);
        for (int i = 0; i < NT; i++) check("one_pulse_per_target", pulses[i] - snap[i], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEADBEEF, 2'b01};
        vecs[1] = '{8'h01, 8'h23, 8'h45, 8'h67, 32'h01234567, 2'b10};
        vecs[2] = '{8'hA5, 8'hC3, 8'h0F, 8'hF0, 32'hA5C30FF0, 2'b01};
        vecs[3] = '{8'h80, 8'h00, 8'h7E, 8'h01, 32'h80007E01, 2'b10};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        start2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;
        repeat (3) tick();
        check("rst_ready", in_ready, 0);
        check("rst_cen", cen_out, 0);
        check("rst_cfg", config_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Idle ignores words.
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        check("idle_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        in_valid = 1'b0;

        // Basic sequences straight from the table.
        for (int s = 0; s < 2; s++) begin
            do_start();
            run_frames(2 * s, 1'b0, 1'b0);
            finish_seq(xor_model(2 * s), 1'b0);
        end

        // Backpressure: valid toggles every cycle.
        do_start();
        run_frames(0, 1'b1, 1'b0);
        finish_seq(xor_model(0), 1'b0);

        // Start held during the second word is ignored.
        do_start();
        run_frames(2, 1'b0, 1'b1);
        finish_seq(xor_model(2), 1'b0);

`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
        // Wrong trailer flags err; the following start clears it.
        do_start();
        run_frames(0, 1'b0, 1'b0);
        finish_seq(xor_model(0) ^ 8'h01, 1'b1);
        check("err_held", err, 1);
`endif

        // Reset during target 1's third word.
        do_start();
        for (int k = 0; k < 4; k++) send_word(word_of(vecs[0], k), 1'b0);
        check("abort_cen0", cen_out, 2'b01);
        tick();
        send_word(word_of(vecs[1], 0), 1'b0);
        send_word(word_of(vecs[1], 1), 1'b0);
        in_valid = 1'b1; in_data = word_of(vecs[1], 2); rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("abort_ready", in_ready, 0);
        check("abort_cen", cen_out, 0);
        check("abort_cfg", config_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_no_tgt1", pulses[1] - snap[1], 0);
        do_start();
        run_frames(0, 1'b0, 1'b0);
        finish_seq(xor_model(0), 1'b0);

        // Degenerate instance: one 16-bit word per frame, one target.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("small_busy", busy2, 1);
        check("small_ready", in_ready2, 1);
        in_valid2 = 1'b1; in_data2 = 16'hBEEF;
        tick();
        in_valid2 = 1'b0;
        check("small_cen", cen_out2, 1);
        check("small_cfg", config_out2, 16'hBEEF);
        tick();
        check("small_cen_fall", cen_out2, 0);
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
        check("small_check_ready", in_ready2, 1);
        in_valid2 = 1'b1; in_data2 = 16'hBEEF;
        tick();
        in_valid2 = 1'b0;
        check("small_err", err2, 0);
`endif
        check("small_done", done2, 1);
        check("small_busy_end", busy2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
